// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator for the draw stage.
// Produces pixel coordinates for frame-buffer fetch, takes the colour back
// after PIXEL_LATENCY clocks and drives sync/blank/colour aligned to it.
// Optional build macro: VGA_TEST_PATTERN_EN (rgb_out shows 64-pixel colour
// bars taken from horReg[8:6] instead of rgb_in).
module vga_timing #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int CLK_DIV       = 2,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  rgb_in,
    output logic [10:0] horReg,
    output logic [9:0]  verReg,
    output logic        pixel_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [2:0]  rgb_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line word: bit0 hsync, bit1 vsync, bit2 active, [5:3] bar colour.
`ifdef VGA_TEST_PATTERN_EN
    localparam int DW = 6;
`else
    localparam int DW = 3;
`endif
    // Inactive word: both syncs high, not active, colour 0.
    localparam logic [DW-1:0] DLY_IDLE = DW'(3'b011);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hor_q, hor_d;
    logic [9:0]       ver_q, ver_d;
    logic             tick_q, tick_d;
    logic             fs_q, fs_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             tick_now;
    logic [DW-1:0]    raw_term;
    logic [DW-1:0]    tap;
    logic [2:0]       colour_src;
    logic [DW-1:0]    dly_q [PIXEL_LATENCY];
    logic [DW-1:0]    dly_d [PIXEL_LATENCY];

    // Clock divider and raster counters; both counters wrap on the same tick.
    always_comb begin
        div_d    = div_q;
        hor_d    = hor_q;
        ver_d    = ver_q;
        fs_d     = 1'b0;
        tick_now = (div_q == DIV_LAST);
        if (tick_now) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (tick_now) begin
            if (hor_q == H_LAST) begin
                hor_d = '0;
                if (ver_q == V_LAST) begin
                    ver_d = '0;
                    fs_d  = 1'b1;
                end else begin
                    ver_d = ver_q + 10'd1;
                end
            end else begin
                hor_d = hor_q + 11'd1;
            end
        end
        // Registered so that pixel_tick is high exactly while div_cnt is at its last value.
        tick_d = (div_d == DIV_LAST);
    end

    // Raw sync/active terms decoded from the current coordinates.
    always_comb begin
        raw_term    = '0;
        raw_term[0] = !((hor_q >= HS_START) && (hor_q < HS_END));
        raw_term[1] = !((ver_q >= VS_START) && (ver_q < VS_END));
        raw_term[2] = (hor_q < H_VIS) && (ver_q < V_VIS);
`ifdef VGA_TEST_PATTERN_EN
        raw_term[5:3] = hor_q[8:6];
`endif
    end

    // Per-clock shift register matching the draw stage's read latency.
    always_comb begin
        dly_d[0] = raw_term;
        for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        tap = dly_q[PIXEL_LATENCY-1];
    end

    // Output stage: delayed timing bits plus colour gated by the active bit.
    always_comb begin
`ifdef VGA_TEST_PATTERN_EN
        colour_src = tap[5:3];
`else
        colour_src = rgb_in;
`endif
        hs_d    = tap[0];
        vs_d    = tap[1];
        blank_d = tap[2];
        rgb_d   = tap[2] ? colour_src : '0;
    end

    // All state; reset loads the inactive values so no sync glitch follows release.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            hor_q   <= '0;
            ver_q   <= '0;
            tick_q  <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
            for (int unsigned i = 0; i < PIXEL_LATENCY; i++) begin
                dly_q[i] <= DLY_IDLE;
            end
        end else begin
            div_q   <= div_d;
            hor_q   <= hor_d;
            ver_q   <= ver_d;
            tick_q  <= tick_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            for (int unsigned i = 0; i < PIXEL_LATENCY; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign horReg      = hor_q;
    assign verReg      = ver_q;
    assign pixel_tick  = tick_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank_n     = blank_q;
    assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing with a shortened frame
// (full 800-pixel lines, 8 lines per frame) so whole frames fit in the run.
// Expected outputs are derived from the clock count since reset release.
module tb_vga_timing;

    localparam int HV = 640, HF = 16, HSY = 96, HB = 48;
    localparam int VV = 4, VF = 1, VSY = 2, VB = 1;
    localparam int CD = 2, PL = 2;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT * CD;
    localparam int LAT = PL + 1;
    localparam int RST_H = 700;
    localparam int RST_V = VV + VF;

    logic        clock;
    logic        reset;
    logic [2:0]  rgb_in;
    logic [10:0] horReg;
    logic [9:0]  verReg;
    logic        pixel_tick, frame_start, hsync, vsync, blank_n;
    logic [2:0]  rgb_out;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .CLK_DIV(CD), .PIXEL_LATENCY(PL)
    ) dut (
        .clock(clock), .reset(reset), .rgb_in(rgb_in),
        .horReg(horReg), .verReg(verReg), .pixel_tick(pixel_tick),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .rgb_out(rgb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        tick;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [2:0]  rgb;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   n      = 0;
    bit   drv_f  = 1'b0;
    bit   hit;

    function automatic int hpos(int k);
        return (k / CD) % HT;
    endfunction

    function automatic int vpos(int k);
        return (k / (CD * HT)) % VT;
    endfunction

    function automatic logic [2:0] colour_fn(int h);
        return 3'((h ^ (h >> 3)) & 7);
    endfunction

    // Expected outputs after the k-th clock edge since reset release.
    function automatic exp_t model(int k, logic rst, bit fmode);
        exp_t e;
        int   hk, vk;
        e = '{h: '0, v: '0, tick: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 3'b000};
        if (!rst) begin
            e.h    = 11'(hpos(k));
            e.v    = 10'(vpos(k));
            e.tick = (k % CD == CD - 1);
            e.fs   = (k > 0) && (k % FRAME == 0);
            if (k >= LAT) begin
                hk   = hpos(k - LAT);
                vk   = vpos(k - LAT);
                e.hs = !((hk >= HV + HF) && (hk < HV + HF + HSY));
                e.vs = !((vk >= VV + VF) && (vk < VV + VF + VSY));
                e.bl = (hk < HV) && (vk < VV);
`ifdef VGA_TEST_PATTERN_EN
                e.rgb = e.bl ? 3'((hk >> 6) & 7) : 3'b000;
`else
                e.rgb = e.bl ? (fmode ? colour_fn(hk) : 3'b101) : 3'b000;
`endif
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per clock and compares every output.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("horReg",      int'(horReg),      int'(e.h));
            chk("verReg",      int'(verReg),      int'(e.v));
            chk("pixel_tick",  int'(pixel_tick),  int'(e.tick));
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("hsync",       int'(hsync),       int'(e.hs));
            chk("vsync",       int'(vsync),       int'(e.vs));
            chk("blank_n",     int'(blank_n),     int'(e.bl));
            chk("rgb_out",     int'(rgb_out),     int'(e.rgb));
        end
    end

    // One clock: record the expectation for this edge, then drive the next inputs.
    // rmode: 0 reset low, 1 reset high, 2 raise reset once the raster sits at (RST_H,RST_V).
    task automatic step(input int rmode, input bit fnext, output bit found);
        exp_t e;
        @(posedge clock);
        if (reset) n = 0;
        else       n = n + 1;
        e = model(n, reset, drv_f);
        sb.push_back(e);
        found = (rmode == 2) && !reset && (hpos(n) == RST_H) && (vpos(n) == RST_V);
        #1;
        reset = (rmode == 1) || found;
        drv_f = fnext;
        if (fnext) rgb_in = (n >= PL) ? colour_fn(hpos(n - PL)) : 3'b000;
        else       rgb_in = 3'b101;
    endtask

    initial begin
        reset  = 1'b1;
        rgb_in = 3'b101;
        // Three reset edges, then a full frame plus margin with constant colour.
        repeat (2) step(1, 1'b0, hit);
        step(0, 1'b0, hit);
        repeat (FRAME + 200) step(0, 1'b0, hit);
        // A full frame with colour returned as a function of the delayed column.
        repeat (FRAME) step(0, 1'b1, hit);
        // Run to the mid-frame point inside both sync pulses and reset there.
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) step(2, 1'b1, hit);
        tests++;
        if (!hit) begin
            failed++;
            $display("FAIL reset_target: got no_hit expected hit within %0d clocks", 2 * FRAME);
        end
        step(1, 1'b1, hit);
        repeat (3000) step(0, 1'b1, hit);
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
